// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared state encoding, default parameters and width helper for ram_ctrl.
package ram_ctrl_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 12;
  localparam int RD_LAT_DEF = 1;
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } st_e;
  function automatic int idx_w(input int d);
    return d <= 1 ? 1 : $clog2(d);
  endfunction
endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/response bus of ram_ctrl.
// Signals: req_valid/req_ready/req_we/req_addr/req_wdata (+req_be with RAM_CTRL_BE_EN),
// rsp_valid/rsp_rdata/rsp_err. master = requester, slave = controller.
interface ram_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef RAM_CTRL_BE_EN
  logic [DATA_W/8-1:0] req_be;
`endif
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
`ifdef RAM_CTRL_BE_EN
  modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_addr, req_wdata, req_be,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
`endif
endinterface

// File: rtl/ram_ctrl_array.sv
// ram_ctrl_array: DEPTH x DATA_W storage, one synchronous bit-masked write port, one combinational read port.
// Ports: clk, we_i, waddr_i, wdata_i, wmask_i (1 = bit written), raddr_i, rdata_o.
module ram_ctrl_array
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int IW    = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] wmask_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: RAM controller with zeroing init sweep, range check and RD_LAT-deep response pipeline.
// Ports: clk, rst (sync, active-high), bus (ram_ctrl_if.slave), busy (init sweep in progress).
// Optional feature: define RAM_CTRL_BE_EN for byte write strobes (bus.req_be).
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  ram_ctrl_if.slave  bus,
  output logic       busy
);
  localparam int CW = idx_w(DEPTH);
  logic [0:0]        st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc, oor, init, we_a;
  logic [CW-1:0]     ridx, widx;
  logic [DATA_W-1:0] wdata, wmask, rdata, d_d;
  logic [RD_LAT-1:0] v_q, e_q;
  logic [DATA_W-1:0] d_q [RD_LAT];
  assign init = st_q == ST_INIT;
  // ready is masked by rst so nothing is accepted on a reset edge
  assign bus.req_ready = !init && !rst;
  assign busy = init || rst;
  assign acc = bus.req_valid && bus.req_ready;
  // one extra bit so DEPTH == 2**ADDR_W compares correctly
  assign oor = {1'b0, bus.req_addr} >= (ADDR_W+1)'(DEPTH);
  assign ridx = oor ? '0 : bus.req_addr[CW-1:0];
  assign widx = init ? cnt_q : ridx;
  assign we_a = init || (acc && bus.req_we && !oor);
  assign wdata = init ? '0 : bus.req_wdata;
  assign d_d = acc && !bus.req_we && !oor ? rdata : '0;
  always_comb begin
    wmask = '1;
`ifdef RAM_CTRL_BE_EN
    for (int i = 0; i < DATA_W/8; i++) if (!init && !bus.req_be[i]) wmask[8*i+:8] = '0;
`endif
  end
  always_comb begin
    st_d  = init && cnt_q == CW'(DEPTH-1) ? ST_RUN : st_q;
    cnt_d = init && cnt_q != CW'(DEPTH-1) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_INIT;
      cnt_q <= '0;
      v_q   <= '0;
      e_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      v_q[0] <= acc;
      e_q[0] <= acc && oor;
      d_q[0] <= d_d;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        e_q[i] <= e_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end
  assign bus.rsp_valid = v_q[RD_LAT-1];
  assign bus.rsp_err   = e_q[RD_LAT-1];
  assign bus.rsp_rdata = d_q[RD_LAT-1];
  ram_ctrl_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .we_i   (we_a),
    .waddr_i(widx),
    .wdata_i(wdata),
    .wmask_i(wmask),
    .raddr_i(ridx),
    .rdata_o(rdata)
  );
endmodule
